// File: rtl/prog_loader.sv
// Program loader / RAM-ownership controller: streams DEPTH bytes into program RAM, then hands RAM to the CPU.
// Optional checksum stage is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_mar,
  input  logic [DATA_W-1:0] cpu_bus,
  input  logic              cpu_ri,
  input  logic              cpu_ro,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              cpu_rst,
  output logic              start,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd2,
`endif
    S_LAUNCH = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_run_first;
  logic              w_loading;
  logic              w_abort;
  logic              w_accept;
  logic              w_wr;
  logic              w_last;

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on registered state, and dropping load_req cancels that cycle's transfer.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_loading = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
  assign w_loading = (r_state == S_LOAD);
`endif
  assign w_abort  = w_loading & ~load_req;
  assign w_accept = in_valid & w_loading & ~w_abort;
  assign w_wr     = w_accept & (r_state == S_LOAD);
  assign w_last   = (r_ptr == ADDR_W'(DEPTH - 1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  logic       r_err;

  assign w_sum_next = r_sum + in_data[7:0];

  // The checksum byte passes when it brings the running sum to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && load_req) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_wr) begin
      r_sum <= w_sum_next;
    end else if ((r_state == S_CHECK) && w_accept && (w_sum_next != 8'd0)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_run_first <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_run_first <= (r_state == S_LAUNCH);
      if ((r_state == S_IDLE) && load_req) begin
        r_ptr <= '0;
      end else if (w_wr) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_req) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (w_accept && w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_LAUNCH;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (w_accept) begin
          w_state_next = (w_sum_next == 8'd0) ? S_LAUNCH : S_IDLE;
        end
      end
`endif
      S_LAUNCH: w_state_next = S_RUN;
      S_RUN: begin
        if (load_req) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    owner    = 1'b1;
    cpu_rst  = 1'b1;
    in_ready = w_loading;
    start    = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_LAUNCH: begin
        owner   = 1'b0;
        cpu_rst = 1'b0;
      end
      S_RUN: begin
        owner   = 1'b0;
        cpu_rst = 1'b0;
        done    = 1'b1;
        start   = r_run_first;
      end
      default: ;
    endcase
  end

  // RAM mux follows the registered owner so the CPU never sees a mid-cycle switch.
  always_comb begin
    if (owner) begin
      ram_addr  = r_ptr;
      ram_wdata = in_data;
      ram_we    = w_wr;
      cpu_rdata = '0;
    end else begin
      ram_addr  = cpu_mar;
      ram_wdata = cpu_bus;
      ram_we    = cpu_ri;
      cpu_rdata = cpu_ro ? ram_rdata : '0;
    end
  end

  assign dbg_state = r_state;

endmodule
